fpu_operand_gen: RTL and testbench
==================================

// Module: fpu_operand_gen
// PURPOSE
//  On-board stimulus sequencer for the FPU conversion units. Drives 32-bit operands into the
//  int-to-float stage (op -> itof operand input) over a valid/ready handshake: a fixed corner-case
//  table first, then NUM_RANDOM LFSR operands. Replaces free-running per-field generators so every
//  operand is indexed and reproducible for ILA capture alongside the result.
// PARAMETERS
//  HOLD_CYCLES  4             cycles from one accepted transfer to next op_valid (>=1; 1 = back-to-back)
//  NUM_RANDOM   1024          random operands issued after the corner table (1..65527)
//  LFSR_SEED    32'hACE12468  LFSR start state; value 0 is replaced by 32'h00000001
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  reset     in   1   synchronous, active-low reset
//  start     in   1   pulse; begins a run when in IDLE or DONE
//  op_ready  in   1   downstream accepts op this cycle
//  op        out  32  operand (int32 bit pattern)
//  op_valid  out  1   op is valid
//  op_index  out  16  index of op within run (0-based)
//  busy      out  1   high in CORNER or RANDOM
//  done      out  1   high in DONE
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE, op=0, op_valid=0, op_index=0, busy=0, done=0,
//    lfsr=LFSR_SEED, gap counter=0. Applies mid-run; run abandoned, no partial output held.
//  - States: IDLE -start-> CORNER -8th transfer-> RANDOM -NUM_RANDOM-th transfer-> DONE -start-> CORNER.
//    start ignored in CORNER/RANDOM. On start: lfsr reloaded, op_index=0.
//  - Outputs registered: start sampled at cycle N -> op_valid=1, op=table[0], busy=1 at N+1.
//  - Transfer = op_valid & op_ready. While op_valid & !op_ready: op, op_index held stable.
//  - After transfer at cycle T: op_valid=0 for HOLD_CYCLES-1 cycles, next op valid at T+HOLD_CYCLES;
//    op_index increments by 1 with the new op. HOLD_CYCLES=1: valid stays high, op changes at T+1.
//  - Corner table (index 0..7): 00000000, 00000001, FFFFFFFF, 7FFFFFFF, 80000000, 00FFFFFF,
//    01000001, 80000001.
//  - RANDOM: op = current lfsr; lfsr advances once per accepted random transfer only (not on stall).
//    Galois right-shift, mask 32'h80200003: lfsr <= {1'b0,lfsr[31:1]} ^ (lfsr[0] ? mask : 0).
//    First random op (index 8) = LFSR_SEED (or 1 if seed 0).
//  - Last transfer at T: T+1 op_valid=0, busy=0, done=1; op keeps last value, op_index keeps last index.
//  - start and final transfer same cycle: transfer completes, enter DONE; start not honoured.
//  - op_index = 16-bit unsigned, never exceeds NUM_RANDOM+7.
// CONFIGURATION
//  OPGEN_LOOP_EN defined: DONE is never held; on the final random transfer the block returns to
//    RANDOM (lfsr NOT reloaded, continues sequence), op_index wraps to 8, done pulses high 1 cycle
//    at T+1 while op_valid follows normal gap rules. Soak mode for board runs.
//  OPGEN_LOOP_EN undefined: behaviour as above; DONE held until start or reset.
// TESTING
//  1 reset=0 two cycles, then reset=1, no start -> op_valid=0, op=0, busy=0, done=0 indefinitely.
//  2 HOLD_CYCLES=1, op_ready=1, start at cycle 10 -> ops 00000000..80000001 on cycles 11..18,
//    index 0..7; cycle 19 op=ACE12468 idx 8; cycle 20 op=56709234.
//  3 HOLD_CYCLES=4, op_ready=1 -> op_valid high 1 of every 4 cycles; op_index +1 per pulse.
//  4 op_ready=0 for 5 cycles at index 9 -> op, op_index unchanged; lfsr not advanced; resumes same value.
//  5 NUM_RANDOM=4, op_ready=1 -> 12 transfers then done=1, busy=0, op_valid=0; start -> index 0,
//    op=00000000 again, identical sequence.
//  6 reset=0 mid-RANDOM at index 20 -> next cycle all outputs at reset values, state IDLE;
//    OPGEN_LOOP_EN build with NUM_RANDOM=4: after index 11 next op index 8 = continued LFSR value, done 1-cycle pulse.

Source files
------------

// File: rtl/fpu_operand_gen_if.sv
// Operand stream bus from the FPU operand sequencer to the int-to-float stage.
// master drives op/op_valid/op_index, slave returns op_ready.
interface fpu_operand_gen_if;
   logic [31:0] op;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_index;

   modport master (
      output op,
      output op_valid,
      output op_index,
      input  op_ready
   );

   modport slave (
      input  op,
      input  op_valid,
      input  op_index,
      output op_ready
   );
endinterface

// File: rtl/fpu_operand_gen.sv
// FPU operand sequencer: issues an 8-entry corner-case table followed by NUM_RANDOM
// Galois-LFSR operands over a valid/ready bus, every operand tagged with its run index.
// Build option OPGEN_LOOP_EN: after the last random operand the run wraps back to index 8
// and keeps the LFSR sequence going, pulsing done for one cycle per pass (soak mode).
module fpu_operand_gen #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned NUM_RANDOM  = 1024,
   parameter logic [31:0] LFSR_SEED   = 32'hACE12468
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   fpu_operand_gen_if.master bus,
   output logic              busy,
   output logic              done
);

`ifdef OPGEN_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   localparam logic [31:0]     LfsrMask = 32'h80200003;
   // An all-zero Galois LFSR never leaves zero
   localparam logic [31:0]     SeedEff  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
   localparam logic [15:0]     LastIdx  = 16'(NUM_RANDOM + 7);
   localparam int unsigned     GapW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLoad  = GapW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StCorner, StRandom, StDone} state_e;

   state_e          state_q;
   logic [31:0]     lfsr_q;
   logic [GapW-1:0] gap_q;

   logic        xfer;
   logic        last_xfer;
   logic [31:0] lfsr_nxt;
   logic [15:0] idx_nxt;
   logic [31:0] xfer_op;
   logic [31:0] gap_op;

   function automatic logic [31:0] corner(input logic [2:0] i);
      logic [31:0] v;
      unique case (i)
         3'd0: v = 32'h00000000;
         3'd1: v = 32'h00000001;
         3'd2: v = 32'hFFFFFFFF;
         3'd3: v = 32'h7FFFFFFF;
         3'd4: v = 32'h80000000;
         3'd5: v = 32'h00FFFFFF;
         3'd6: v = 32'h01000001;
         3'd7: v = 32'h80000001;
         default: v = 32'h00000000;
      endcase
      return v;
   endfunction

   // Next-operand selection shared by the back-to-back and post-gap load paths
   always_comb begin
      xfer      = bus.op_valid & bus.op_ready;
      lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);
      last_xfer = (state_q == StRandom) && (bus.op_index == LastIdx);
      idx_nxt   = last_xfer ? 16'd8 : bus.op_index + 16'd1;
      // Loaded at the transfer edge (HOLD_CYCLES == 1): LFSR has not stepped yet
      if (state_q == StCorner) begin
         xfer_op = (bus.op_index == 16'd7) ? lfsr_q : corner(idx_nxt[2:0]);
      end else begin
         xfer_op = lfsr_nxt;
      end
      // Loaded at the end of a gap: state and LFSR were already updated at the transfer
      gap_op = (state_q == StCorner) ? corner(idx_nxt[2:0]) : lfsr_q;
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         lfsr_q       <= SeedEff;
         gap_q        <= '0;
         bus.op       <= 32'd0;
         bus.op_valid <= 1'b0;
         bus.op_index <= 16'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q      <= StCorner;
                  lfsr_q       <= SeedEff;
                  gap_q        <= '0;
                  bus.op       <= corner(3'd0);
                  bus.op_valid <= 1'b1;
                  bus.op_index <= 16'd0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
               end
            end
            StCorner, StRandom: begin
               done <= 1'b0;
               if (xfer) begin
                  if (state_q == StRandom) lfsr_q <= lfsr_nxt;
                  if (state_q == StCorner && bus.op_index == 16'd7) state_q <= StRandom;
                  if (last_xfer && !LoopEn) begin
                     // op and op_index keep the final operand for capture
                     state_q      <= StDone;
                     bus.op_valid <= 1'b0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                  end else begin
                     if (last_xfer) done <= 1'b1;
                     if (HOLD_CYCLES == 1) begin
                        bus.op       <= xfer_op;
                        bus.op_index <= idx_nxt;
                     end else begin
                        bus.op_valid <= 1'b0;
                        gap_q        <= GapLoad;
                     end
                  end
               end else if (!bus.op_valid) begin
                  if (gap_q <= GapW'(1)) begin
                     bus.op_valid <= 1'b1;
                     bus.op       <= gap_op;
                     bus.op_index <= idx_nxt;
                     gap_q        <= '0;
                  end else begin
                     gap_q <= gap_q - GapW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_operand_gen.sv
// Bench for fpu_operand_gen: two instances (back-to-back with a short run, and a 4-cycle
// hold with a longer run) checked against an operand-list model driven by random op_ready.
module tb_fpu_operand_gen;
   localparam int unsigned Hold0 = 1;
   localparam int unsigned Nr0   = 4;
   localparam int unsigned Hold1 = 4;
   localparam int unsigned Nr1   = 16;
   localparam logic [31:0] Seed  = 32'hACE12468;
`ifdef OPGEN_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_v [2];
   logic start_v [2];
   logic rdy_v [2];
   logic busy0, busy1, done0, done1;

   logic [31:0] s_op [2];
   logic        s_valid [2];
   logic [15:0] s_idx [2];
   logic        s_busy [2];
   logic        s_done [2];

   int total;
   int bad;

   logic [31:0] corner_tbl [8] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                   32'h80000000, 32'h00FFFFFF, 32'h01000001, 32'h80000001};

   fpu_operand_gen_if bus0 ();
   fpu_operand_gen_if bus1 ();

   assign bus0.op_ready = rdy_v[0];
   assign bus1.op_ready = rdy_v[1];
   assign s_op[0] = bus0.op;
   assign s_op[1] = bus1.op;
   assign s_valid[0] = bus0.op_valid;
   assign s_valid[1] = bus1.op_valid;
   assign s_idx[0] = bus0.op_index;
   assign s_idx[1] = bus1.op_index;
   assign s_busy[0] = busy0;
   assign s_busy[1] = busy1;
   assign s_done[0] = done0;
   assign s_done[1] = done1;

   fpu_operand_gen #(.HOLD_CYCLES(Hold0), .NUM_RANDOM(Nr0), .LFSR_SEED(Seed)) u_dut0 (
      .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .bus(bus0), .busy(busy0), .done(done0)
   );

   fpu_operand_gen #(.HOLD_CYCLES(Hold1), .NUM_RANDOM(Nr1), .LFSR_SEED(Seed)) u_dut1 (
      .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .bus(bus1), .busy(busy1), .done(done1)
   );

   function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h00000000);
   endfunction

   task automatic do_reset(input int d);
      @(negedge clk);
      rst_v[d] = 1'b0;
      start_v[d] = 1'b0;
      rdy_v[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_v[d] = 1'b1;
   endtask

   // Starts a run on instance d and follows it against the operand-list model.
   // Ends at the run's end, after n_xfer transfers, or when index stop_at is first presented.
   task automatic run_stream(input int d, input int n_xfer, input int stall_pct,
                             input int stall_at, input int stop_at);
      int hold, last, exp_idx, gap, xfers, stalls, cyc;
      bit exp_valid, pend_done, fin, r;
      logic [31:0] m_lfsr, exp_op, last_op;
      hold = (d == 0) ? Hold0 : Hold1;
      last = ((d == 0) ? Nr0 : Nr1) + 7;
      @(negedge clk);
      start_v[d] = 1'b1;
      rdy_v[d] = 1'b0;
      @(negedge clk);
      start_v[d] = 1'b0;
      exp_valid = 1'b1; exp_idx = 0; m_lfsr = Seed; gap = 0; xfers = 0; stalls = 0; cyc = 0;
      pend_done = 1'b0; fin = 1'b0; last_op = 32'd0;
      while (!fin) begin
         if (exp_idx < 8) exp_op = corner_tbl[exp_idx];
         else exp_op = m_lfsr;
         total++;
         if (s_busy[d] !== 1'b1) begin
            bad++;
            $display("FAIL stream%0d busy: got %b want 1 (idx %0d)", d, s_busy[d], exp_idx);
         end
         total++;
         if (s_done[d] !== pend_done) begin
            bad++;
            $display("FAIL stream%0d done: got %b want %b", d, s_done[d], pend_done);
         end
         total++;
         if (s_valid[d] !== exp_valid) begin
            bad++;
            $display("FAIL stream%0d op_valid: got %b want %b (idx %0d)", d, s_valid[d],
                     exp_valid, exp_idx);
         end
         if (exp_valid) begin
            total++;
            if (s_op[d] !== exp_op) begin
               bad++;
               $display("FAIL stream%0d op: got %h want %h (idx %0d)", d, s_op[d], exp_op,
                        exp_idx);
            end
            total++;
            if (s_idx[d] !== 16'(exp_idx)) begin
               bad++;
               $display("FAIL stream%0d op_index: got %0d want %0d", d, s_idx[d], exp_idx);
            end
         end
         pend_done = 1'b0;
         if (exp_valid && exp_idx == stop_at) begin
            rdy_v[d] = 1'b0;
            return;
         end
         if (exp_valid && exp_idx == stall_at && stalls < 5) begin
            r = 1'b0;
            stalls++;
         end else begin
            r = ($urandom_range(99) >= stall_pct);
         end
         rdy_v[d] = r;
         if (exp_valid && r) begin
            xfers++;
            last_op = exp_op;
            if (exp_idx >= 8) m_lfsr = lfsr_adv(m_lfsr);
            if (exp_idx == last) begin
               if (LoopEn) begin
                  exp_idx = 8;
                  pend_done = 1'b1;
               end else begin
                  fin = 1'b1;
               end
            end else begin
               exp_idx++;
            end
            if (hold > 1) begin
               exp_valid = 1'b0;
               gap = hold - 1;
            end
            if (xfers >= n_xfer && !fin) return;
         end else if (!exp_valid) begin
            gap--;
            if (gap == 0) exp_valid = 1'b1;
         end
         cyc++;
         if (cyc > 20000) begin
            total++;
            bad++;
            $display("FAIL stream%0d timeout: got %0d transfers want run end", d, xfers);
            return;
         end
         @(negedge clk);
      end
      rdy_v[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (s_done[d] !== 1'b1 || s_busy[d] !== 1'b0 || s_valid[d] !== 1'b0) begin
            bad++;
            $display("FAIL end%0d flags: got done=%b busy=%b valid=%b want 1 0 0", d,
                     s_done[d], s_busy[d], s_valid[d]);
         end
         total++;
         if (s_op[d] !== last_op || s_idx[d] !== 16'(last)) begin
            bad++;
            $display("FAIL end%0d hold: got %h/%0d want %h/%0d", d, s_op[d], s_idx[d],
                     last_op, last);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b1; rst_v[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            total++;
            if (s_valid[d] !== 1'b0 || s_busy[d] !== 1'b0 || s_done[d] !== 1'b0 ||
                s_op[d] !== 32'd0 || s_idx[d] !== 16'd0) begin
               bad++;
               $display("FAIL reset%0d: got v=%b b=%b d=%b op=%h idx=%0d want all 0", d,
                        s_valid[d], s_busy[d], s_done[d], s_op[d], s_idx[d]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] lit [10] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                32'h80000000, 32'h00FFFFFF, 32'h01000001, 32'h80000001,
                                32'hACE12468, 32'h56709234};
      do_reset(0);
      rdy_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (s_valid[0] !== 1'b1 || s_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b flags cycle %0d: got v=%b b=%b want 1 1", i, s_valid[0],
                     s_busy[0]);
         end
         total++;
         if (s_op[0] !== lit[i] || s_idx[0] !== 16'(i)) begin
            bad++;
            $display("FAIL b2b op: got %h/%0d want %h/%0d", s_op[0], s_idx[0], lit[i], i);
         end
         @(negedge clk);
      end
      do_reset(0);
   endtask

   task automatic test_done_restart();
      do_reset(0);
      run_stream(0, 3 * (Nr0 + 8), 30, -1, -1);
      if (LoopEn) do_reset(0);
      run_stream(0, 3 * (Nr0 + 8), 30, -1, -1);
      do_reset(0);
   endtask

   task automatic test_hold_gap();
      do_reset(1);
      run_stream(1, 2 * (Nr1 + 8), 0, -1, -1);
      do_reset(1);
   endtask

   task automatic test_stall();
      do_reset(1);
      run_stream(1, Nr1 + 12, 40, 9, -1);
      do_reset(1);
   endtask

   task automatic test_mid_reset();
      do_reset(1);
      run_stream(1, 1000, 0, -1, 20);
      rst_v[1] = 1'b0;
      @(negedge clk);
      rst_v[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (s_valid[1] !== 1'b0 || s_busy[1] !== 1'b0 || s_done[1] !== 1'b0 ||
             s_op[1] !== 32'd0 || s_idx[1] !== 16'd0) begin
            bad++;
            $display("FAIL midreset cycle %0d: got v=%b b=%b d=%b op=%h idx=%0d want all 0",
                     k, s_valid[1], s_busy[1], s_done[1], s_op[1], s_idx[1]);
         end
         @(negedge clk);
      end
      run_stream(1, 12, 20, -1, -1);
      do_reset(1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b0;
         start_v[d] = 1'b0;
         rdy_v[d] = 1'b0;
      end
      test_reset();
      test_back_to_back();
      test_done_restart();
      test_hold_gap();
      test_stall();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
